// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor with a multiplexed common-anode
// seven-segment driver that scans the held result plus a carry/sign position.
module bcd_addsub_seq #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                cout,
    output logic                err,
    output logic [6:0]          seg,
    output logic [DIGITS:0]     an
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]  a_sh, b_sh, work, work_nxt;
    logic [IW-1:0] idx;
    logic          carry, sub_q, err_int, res_sub;
    logic          last_digit, any_bad, c_nxt;
    logic [3:0]    bd, dig;
    logic [4:0]    s, sm10;

    logic [REFRESH_BITS-1:0] presc;
    logic [PW-1:0]           pos;
    logic [3:0]              cur_digit;

    assign last_digit = (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADD;
            S_ADD:   if (last_digit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_comb begin
        any_bad = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) any_bad = 1'b1;
        end
    end

    // Operands shift right so the digit being processed is always in [3:0].
    always_comb begin
        bd    = sub_q ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
        s     = {1'b0, a_sh[3:0]} + {1'b0, bd} + {4'b0, carry};
        sm10  = s - 5'd10;
        if (s > 5'd9) begin
            dig   = sm10[3:0];
            c_nxt = 1'b1;
        end else begin
            dig   = s[3:0];
            c_nxt = 1'b0;
        end
        work_nxt = (work >> 4) | (W'(dig) << (W - 4));
    end

    // The result is committed on the last digit edge so it is already valid
    // during the DONE cycle alongside the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            work    <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            sub_q   <= 1'b0;
            err_int <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            res_sub <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    sub_q   <= mode;
                    carry   <= mode ? 1'b1 : cin;
                    idx     <= '0;
                    err_int <= any_bad;
                end
                S_ADD: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    work  <= work_nxt;
                    carry <= c_nxt;
                    idx   <= idx + 1'b1;
                    if (last_digit) begin
                        result  <= err_int ? '0 : work_nxt;
                        cout    <= err_int ? 1'b0 : (sub_q ? ~c_nxt : c_nxt);
                        err     <= err_int;
                        res_sub <= sub_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pos   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (presc == '1) begin
                if (pos == PW'(DIGITS)) pos <= '0;
                else                    pos <= pos + 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (pos == PW'(k)) cur_digit = result[4*k +: 4];
        end
        for (int unsigned k = 0; k <= DIGITS; k++) begin
            an[k] = (pos != PW'(k));
        end
    end

    always_comb begin
        seg = 7'b1111111;
        if (err) begin
            seg = 7'b0110000;
        end else if (pos == PW'(DIGITS)) begin
            if (cout) seg = res_sub ? 7'b1111110 : 7'b1001111;
        end else begin
            case (cur_digit)
                4'd0:    seg = 7'b0000001;
                4'd1:    seg = 7'b1001111;
                4'd2:    seg = 7'b0010010;
                4'd3:    seg = 7'b0000110;
                4'd4:    seg = 7'b1001100;
                4'd5:    seg = 7'b0100100;
                4'd6:    seg = 7'b0100000;
                4'd7:    seg = 7'b0001111;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0000100;
                default: seg = 7'b1111111;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Randomized self-checking bench for bcd_addsub_seq (DIGITS=4, REFRESH_BITS=2)
// against an integer-arithmetic reference model.
module tb_bcd_addsub_seq;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [15:0]   a = '0, b = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout, err;
    logic [15:0]   result;
    logic [6:0]    seg;
    logic [4:0]    an;

    int total = 0;
    int bad   = 0;

    // expected outcome of the most recent operation
    logic [15:0] exp_res;
    logic        exp_cout, exp_err, exp_sub;

    bcd_addsub_seq #(.DIGITS(D), .REFRESH_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
        .err(err), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic m, input logic c);
        int x, y, v;
        logic badd = 1'b0;
        for (int k = 0; k < D; k++)
            if (av[4*k +: 4] > 9 || bv[4*k +: 4] > 9) badd = 1'b1;
        x = bcd2int(av);
        y = bcd2int(bv);
        exp_sub = m;
        exp_err = badd;
        if (badd) begin
            exp_res = '0; exp_cout = 1'b0;
        end else if (!m) begin
            v = x + y + int'(c);
            exp_res = int2bcd(v % 10000); exp_cout = (v >= 10000);
        end else if (x >= y) begin
            exp_res = int2bcd(x - y); exp_cout = 1'b0;
        end else begin
            exp_res = int2bcd(10000 + x - y); exp_cout = 1'b1;
        end
    endtask

    function automatic logic [6:0] exp_seg(input int p);
        if (exp_err) return 7'b0110000;
        if (p == D) begin
            if (!exp_cout) return 7'b1111111;
            return exp_sub ? 7'b1111110 : 7'b1001111;
        end
        return seg_of(int'(exp_res[4*p +: 4]));
    endfunction

    // Issues one operation and checks busy/done timing, result and flags.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic m, input logic c);
        int n = 0;
        model(av, bv, m, c);
        @(negedge clk);
        a = av; b = bv; mode = m; cin = c; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; a = 16'h5A5A; b = 16'hA5A5; mode = ~m; cin = ~c;
            end
            total++;
            if (busy !== 1'b1) begin
                bad++; $display("FAIL busy_high k=%0d got=%b want=1", k, busy);
            end
            if (done === 1'b1) begin n = k; break; end
        end
        total++;
        if (n != D + 1) begin
            bad++; $display("FAIL done_latency got=%0d want=%0d", n, D + 1);
        end
        total++;
        if (result !== exp_res || cout !== exp_cout || err !== exp_err) begin
            bad++;
            $display("FAIL op a=%h b=%h m=%b c=%b got res=%h cout=%b err=%b want res=%h cout=%b err=%b",
                     av, bv, m, c, result, cout, err, exp_res, exp_cout, exp_err);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL after_done got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    // Waits (bounded) until position p is active and checks its segments.
    task automatic check_pos(input int p);
        logic [4:0] want_an = ~(5'b1 << p);
        int seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an === want_an) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL pos_timeout p=%0d got an=%b want=%b", p, an, want_an);
        end else if (seg !== exp_seg(p)) begin
            bad++; $display("FAIL seg p=%0d got=%b want=%b", p, seg, exp_seg(p));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (busy !== 0 || done !== 0 || result !== 16'h0 || cout !== 0 || err !== 0 ||
            an !== 5'b11110 || seg !== 7'b0000001) begin
            bad++; $display("FAIL reset_state got busy=%b done=%b res=%h cout=%b err=%b an=%b seg=%b",
                            busy, done, result, cout, err, an, seg);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        int dones = 0;
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h9999; b = 16'h0001; mode = 0; cin = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 0 || done !== 0 || result !== 16'h0 || an !== 5'b11110 || seg !== 7'b0000001) begin
            bad++; $display("FAIL reset_mid_op got busy=%b done=%b res=%h an=%b seg=%b",
                            busy, done, result, an, seg);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || result !== 16'h0) begin
            bad++; $display("FAIL reset_no_done got dones=%0d res=%h want 0 0000", dones, result);
        end
        model(16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_directed();
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0); check_pos(D);
        do_op(16'h1234, 16'h5678, 1'b0, 1'b1);
        do_op(16'h0500, 16'h0123, 1'b1, 1'b0); check_pos(D);
        do_op(16'h0003, 16'h0005, 1'b1, 1'b1); check_pos(D);
        for (int p = 0; p < D; p++) check_pos(p);
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        do_op(16'h9999, 16'h9999, 1'b0, 1'b1);
    endtask

    task automatic test_err();
        do_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
        for (int p = 0; p <= D; p++) check_pos(p);
        do_op(16'h0001, 16'hF000, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        model(16'h2468, 16'h1357, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'h2468; b = 16'h1357; mode = 0; cin = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); a = 16'h9999; b = 16'h9999; mode = 1; start = 1;
        @(negedge clk); start = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 1 || result !== exp_res || cout !== exp_cout) begin
            bad++; $display("FAIL ignored_start got dones=%0d res=%h cout=%b want 1 %h %b",
                            dones, result, cout, exp_res, exp_cout);
        end
    endtask

    task automatic test_random();
        logic [15:0] av, bv;
        for (int t = 0; t < 40; t++) begin
            av = rand_bcd(); bv = rand_bcd();
            if ($urandom_range(0, 9) == 0) av[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            do_op(av, bv, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        do_op(16'h4321, 16'h1111, 1'b1, 1'b0);
        do_op(16'h0001, 16'h0002, 1'b1, 1'b0);
        do_op(16'h5000, 16'h5000, 1'b0, 1'b0);
    endtask

    task automatic test_scan();
        int p0 = -1, p;
        logic [4:0] prev;
        @(negedge clk); prev = an;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (an !== prev) begin
                for (int q = 0; q <= D; q++) if (an === ~(5'b1 << q)) p0 = q;
                break;
            end
        end
        total++;
        if (p0 < 0) begin
            bad++; $display("FAIL scan_start got an=%b want a single low bit changing", an);
        end else begin
            for (int k = 0; k < 20; k++) begin
                p = (p0 + k / 4) % (D + 1);
                total++;
                if (an !== ~(5'b1 << p) || seg !== exp_seg(p)) begin
                    bad++; $display("FAIL scan k=%0d got an=%b seg=%b want an=%b seg=%b",
                                    k, an, seg, ~(5'b1 << p), exp_seg(p));
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err();
        test_ignored_start();
        test_back_to_back();
        test_random();
        do_op(16'h0003, 16'h0005, 1'b1, 1'b0);
        test_scan();
        test_reset_mid_op();
        test_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_addsub_seq.md
# bcd_addsub_seq

Parametrised, digit-serial BCD adder/subtractor with an integrated multiplexed seven-segment driver. It is the successor to the board's fixed 2-digit combinational BCD adder. It accepts DIGITS-wide packed-BCD operands on a start handshake and computes A+B+cin or A−B one digit per clock. It holds the registered result and continuously scans it, plus a carry/sign position, onto DIGITS+1 common-anode displays.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1).
- REFRESH_BITS, 18: prescaler width; display advances one position each 2^REFRESH_BITS clocks (≥1).
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = add, 1 = subtract (A−B); sampled with start.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  carry-in for add; ignored in subtract.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when result/flags update.
- result  output  4*DIGITS  registered BCD result.
- cout  output  1  add: decimal carry out; subtract: 1 = borrow (A<B).
- err  output  1  1 = last operation had a non-BCD input digit.
- seg  output  7  active-low segments, seg[6]=a … seg[0]=g.
- an  output  DIGITS+1  active-low position enables, an[0] = least significant digit, an[DIGITS] = carry/sign position.

## Operation
- FSM: IDLE → ADD → DONE → IDLE.
- IDLE: on start=1, latch a, b, mode, and carry seed (cin if add, 1 if sub), clear digit index i, set err_int if any latched digit >9, go to ADD.
- ADD: one digit per cycle; bd = b_i (add) or 9−b_i (sub); s = a_i + bd + c (5-bit); if s>9, digit = s−10 and c = 1, else digit = s and c = 0. Store into working register, i++. After i = DIGITS−1, go to DONE.
- DONE: copy working register to result. cout = c (add) or ~c (sub). err = err_int. Pulse done. Return to IDLE.
- Subtract with borrow yields the DIGITS-digit ten's complement (e.g., 0003−0005 = 9998, cout=1). No re-complementing.
- err=1: result forced to all zero, cout=0, latency unchanged.
- start while busy: ignored, no queueing. Inputs a/b/mode/cin may change freely after the start cycle.
- Display: free-running REFRESH_BITS prescaler. On wrap, position p increments, wrapping from DIGITS to 0. Only one an bit is low.
- Display source: p<DIGITS shows result digit p. p=DIGITS shows "1" if add with cout=1, "−" (1111110) if sub with cout=1, otherwise blank (1111111). err=1 shows "E" (0110000) on every position.
- Digit patterns (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Display always shows the held result, never in-flight work.

## Timing
- Reset (async assert, sync release): state IDLE, busy=0, done=0, result=0, cout=0, err=0, prescaler=0, p=0. Outputs an = all ones except an[0]=0, seg=0000001.
- start sampled at edge T0. busy=1 from T0+1 through DONE cycle T0+DIGITS+1 inclusive. done=1 only in T0+DIGITS+1, and result/cout/err valid from that cycle.
- Earliest next start is accepted at edge T0+DIGITS+2. Throughput is one operation per DIGITS+2 cycles.
- Reset mid-operation aborts immediately. The partial result is discarded and no done is issued.
- The done cycle and a prescaler wrap may coincide. The new position uses the new result in the same cycle.
- result/cout/err are stable between done pulses.

## Test plan
- Reset: assert rst_n=0 mid-ADD → busy=0, done=0, result=0000, an=11110, seg=0000001 immediately. No done after release.
- Add with carry (DIGITS=4): a=9999, b=0001, cin=0, start → done at T0+5, result=0000, cout=1, busy high T0+1..T0+5. Position 4 shows 1001111.
- Add with cin: a=1234, b=5678, cin=1 → result=6913, cout=0, err=0.
- Subtract: a=0500, b=0123, mode=1 → 0377, cout=0. Then a=0003, b=0005 → 9998, cout=1, position 4 shows 1111110.
- Invalid/ignored start: a=12A4 → err=1, result=0000, all seg=0110000. Pulse start at T0+2 of a valid operation → ignored, exactly one done.
- Scan (REFRESH_BITS=2): an cycles 11110→11101→11011→10111→01111→11110, advancing every 4 clocks. seg matches each result digit.
